// File: rtl/bist_controller_if.sv
// Test-host/CUT-facing bundle of the BIST controller.
// The controller takes the slave side and the test host takes the master side.
`timescale 1ns/1ps
interface bist_controller_if #(
  parameter int unsigned WIDTH  = 9,
  parameter int unsigned RESP_W = 9,
  parameter int unsigned CNT_W  = 10
);
  logic              start;
  logic              abort;
  logic [RESP_W-1:0] cut_resp;
  logic              lfsr_load;
  logic [WIDTH-1:0]  lfsr_seed;
  logic              lfsr_en;
  logic              test_mode;
  logic              busy;
  logic              done;
  logic              pass;
  logic [RESP_W-1:0] signature;
  logic [CNT_W-1:0]  pattern_cnt;

  modport master (
    output start, abort, cut_resp,
    input  lfsr_load, lfsr_seed, lfsr_en, test_mode, busy, done, pass, signature, pattern_cnt
  );

  modport slave (
    input  start, abort, cut_resp,
    output lfsr_load, lfsr_seed, lfsr_en, test_mode, busy, done, pass, signature, pattern_cnt
  );
endinterface

// File: rtl/bist_controller.sv
// BIST session sequencer: seeds and steps the pattern LFSR, compacts CUT responses
// into a MISR and compares the final signature against a golden value.
`timescale 1ns/1ps
module bist_controller #(
  parameter int unsigned       WIDTH        = 9,
  parameter int unsigned       RESP_W       = 9,
  parameter int unsigned       NUM_PATTERNS = 511,
  parameter int unsigned       RESP_LAT     = 1,
  parameter logic [WIDTH-1:0]  SEED         = 'h00F,
  parameter logic [RESP_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic              clk,
  input  logic              reset,
  bist_controller_if.slave  bus
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned CYC_W = 11;

  localparam logic [CNT_W-1:0] NP_C       = CNT_W'(NUM_PATTERNS);
  localparam logic [CYC_W-1:0] RUN_LAST   = CYC_W'(NUM_PATTERNS - 1);
  localparam logic [CYC_W-1:0] FLUSH_LAST = CYC_W'(NUM_PATTERNS + RESP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_RUN     = 3'd2,
    S_FLUSH   = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // With zero response latency the last capture happens in RUN, so FLUSH is skipped.
  localparam state_t RUN_EXIT = (RESP_LAT == 0) ? S_COMPARE : S_FLUSH;

  state_t r_state;
  state_t w_next_state;

  logic              r_lfsr_load, r_lfsr_en, r_test_mode, r_busy, r_done, r_pass;
  logic              w_lfsr_load, w_lfsr_en, w_test_mode, w_busy, w_done, w_pass;
  logic [RESP_W-1:0] r_misr;
  logic [CNT_W-1:0]  r_pattern_cnt;
  logic [CYC_W-1:0]  r_cyc_cnt;
  logic [RESP_W-1:0] w_misr_shift;
  logic              w_in_window;
  logic              w_lat_reached;
  logic              w_capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE,
        S_DONE:    if (bus.start) w_next_state = S_SEED;
        S_SEED:    w_next_state = S_RUN;
        S_RUN:     if (r_cyc_cnt == RUN_LAST) w_next_state = RUN_EXIT;
        S_FLUSH:   if (r_cyc_cnt == FLUSH_LAST) w_next_state = S_COMPARE;
        S_COMPARE: w_next_state = S_DONE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    w_lfsr_load = (w_next_state == S_SEED);
    w_lfsr_en   = (w_next_state == S_RUN);
    w_test_mode = (w_next_state == S_RUN) || (w_next_state == S_FLUSH);
    w_busy      = (w_next_state == S_SEED) || (w_next_state == S_RUN) ||
                  (w_next_state == S_FLUSH) || (w_next_state == S_COMPARE);
    w_done      = r_done;
    w_pass      = r_pass;
    if ((w_next_state == S_IDLE) || (w_next_state == S_SEED)) begin
      w_done = 1'b0;
      w_pass = 1'b0;
    end else if ((r_state == S_COMPARE) && (w_next_state == S_DONE)) begin
      w_done = 1'b1;
      w_pass = (r_misr == GOLDEN_SIG);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr_load <= 1'b0;
      r_lfsr_en   <= 1'b0;
      r_test_mode <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_lfsr_load <= w_lfsr_load;
      r_lfsr_en   <= w_lfsr_en;
      r_test_mode <= w_test_mode;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
    end
  end

  // MISR feedback taps x^9+x^4+1 on the low nine bits; response XORed into every stage.
  assign w_misr_shift  = {r_misr[RESP_W-2:0], r_misr[8] ^ r_misr[3]} ^ bus.cut_resp;
  assign w_in_window   = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign w_lat_reached = ((CYC_W+1)'(r_cyc_cnt) + (CYC_W+1)'(1)) > (CYC_W+1)'(RESP_LAT);
  assign w_capture     = w_in_window && w_lat_reached;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misr        <= '0;
      r_pattern_cnt <= '0;
      r_cyc_cnt     <= '0;
    end else if (w_next_state == S_SEED) begin
      r_misr        <= '0;
      r_pattern_cnt <= '0;
      r_cyc_cnt     <= '0;
    end else if (!bus.abort) begin
      if (w_in_window) r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
      if (w_capture)   r_misr    <= w_misr_shift;
      if ((r_state == S_RUN) && (r_pattern_cnt != NP_C))
        r_pattern_cnt <= r_pattern_cnt + CNT_W'(1);
    end
  end

  assign bus.lfsr_load   = r_lfsr_load;
  assign bus.lfsr_seed   = SEED;
  assign bus.lfsr_en     = r_lfsr_en;
  assign bus.test_mode   = r_test_mode;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.signature   = r_misr;
  assign bus.pattern_cnt = r_pattern_cnt;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller using three parameterisations:
// A (3 patterns, no latency, golden 0x007), B (4 patterns, latency 2), C (8 patterns, latency 1).
`timescale 1ns/1ps
module tb_bist_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bist_controller_if #(.WIDTH(9), .RESP_W(9)) bus_a ();
  bist_controller_if #(.WIDTH(9), .RESP_W(9)) bus_b ();
  bist_controller_if #(.WIDTH(9), .RESP_W(9)) bus_c ();

  bist_controller #(.WIDTH(9), .RESP_W(9), .NUM_PATTERNS(3), .RESP_LAT(0),
                    .SEED(9'h00F), .GOLDEN_SIG(9'h007))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  bist_controller #(.WIDTH(9), .RESP_W(9), .NUM_PATTERNS(4), .RESP_LAT(2),
                    .SEED(9'h00F), .GOLDEN_SIG(9'h000))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  bist_controller #(.WIDTH(9), .RESP_W(9), .NUM_PATTERNS(8), .RESP_LAT(1),
                    .SEED(9'h00F), .GOLDEN_SIG(9'h000))
    dut_c (.clk(clk), .reset(reset), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.start = 0; bus_a.abort = 0; bus_a.cut_resp = '0;
    bus_b.start = 0; bus_b.abort = 0; bus_b.cut_resp = '0;
    bus_c.start = 0; bus_c.abort = 0; bus_c.cut_resp = '0;
    #2;
    tick(); tick();
    checks++;
    if ({bus_a.lfsr_load, bus_a.lfsr_en, bus_a.test_mode, bus_a.busy, bus_a.done, bus_a.pass} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {bus_a.lfsr_load, bus_a.lfsr_en, bus_a.test_mode, bus_a.busy, bus_a.done, bus_a.pass});
    end
    checks++;
    if (bus_a.lfsr_seed !== 9'h00F) begin
      errors++; $display("FAIL reset_seed: got %h expected 00f", bus_a.lfsr_seed);
    end
    checks++;
    if (bus_a.signature !== 9'h000 || bus_a.pattern_cnt !== 10'd0) begin
      errors++; $display("FAIL reset_regs: sig %h cnt %0d expected 000 0", bus_a.signature, bus_a.pattern_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_session_a();
    int edges = 0, n_load, n_en = 0;
    bus_a.cut_resp = 9'h001;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.lfsr_load !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.lfsr_en !== 1'b0) begin
      errors++; $display("FAIL a_seed_cycle: load %b busy %b en %b expected 1 1 0",
        bus_a.lfsr_load, bus_a.busy, bus_a.lfsr_en);
    end
    n_load = int'(bus_a.lfsr_load);
    while (bus_a.done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
      n_load += int'(bus_a.lfsr_load);
      n_en   += int'(bus_a.lfsr_en);
    end
    checks++;
    if (edges != 5) begin errors++; $display("FAIL a_latency: done after edge %0d expected 5", edges); end
    checks++;
    if (n_load != 1 || n_en != 3) begin
      errors++; $display("FAIL a_load_en_cycles: load %0d en %0d expected 1 3", n_load, n_en);
    end
    checks++;
    if (bus_a.signature !== 9'h007 || bus_a.pass !== 1'b1) begin
      errors++; $display("FAIL a_signature: sig %h pass %b expected 007 1", bus_a.signature, bus_a.pass);
    end
    checks++;
    if (bus_a.pattern_cnt !== 10'd3 || bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL a_final_cnt: cnt %0d busy %b expected 3 0", bus_a.pattern_cnt, bus_a.busy);
    end
  endtask

  task automatic test_back_to_back();
    int edges = 0;
    tick(); tick();
    checks++;
    if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1) begin
      errors++; $display("FAIL b2b_hold: done %b pass %b expected 1 1", bus_a.done, bus_a.pass);
    end
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.done !== 1'b0 || bus_a.pass !== 1'b0 || bus_a.lfsr_load !== 1'b1 || bus_a.signature !== 9'h000) begin
      errors++; $display("FAIL b2b_seed_clear: done %b pass %b load %b sig %h expected 0 0 1 000",
        bus_a.done, bus_a.pass, bus_a.lfsr_load, bus_a.signature);
    end
    while (bus_a.done !== 1'b1 && edges < 40) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 5 || bus_a.signature !== 9'h007 || bus_a.pass !== 1'b1) begin
      errors++; $display("FAIL b2b_repeat: edges %0d sig %h pass %b expected 5 007 1",
        edges, bus_a.signature, bus_a.pass);
    end
  endtask

  task automatic test_resp_latency();
    logic [8:0] resp [6];
    int edges = 0, n_en = 0, n_tm = 0;
    resp[0] = 9'h1FF; resp[1] = 9'h1FF; resp[2] = 9'h001;
    resp[3] = 9'h004; resp[4] = 9'h100; resp[5] = 9'h001;
    bus_b.cut_resp = 9'h1FF;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    while (bus_b.done !== 1'b1 && edges < 40) begin
      bus_b.cut_resp = (edges >= 1 && edges <= 6) ? resp[edges-1] : 9'h1FF;
      tick();
      edges++;
      n_en += int'(bus_b.lfsr_en);
      n_tm += int'(bus_b.test_mode);
      if (edges == 3) begin
        checks++;
        if (bus_b.signature !== 9'h000) begin
          errors++; $display("FAIL b_no_early_capture: sig %h expected 000", bus_b.signature);
        end
      end
      if (edges == 4) begin
        checks++;
        if (bus_b.signature !== 9'h001) begin
          errors++; $display("FAIL b_first_capture: sig %h expected 001", bus_b.signature);
        end
      end
      if (edges == 6) begin
        checks++;
        if (bus_b.signature !== 9'h10C) begin
          errors++; $display("FAIL b_mid_capture: sig %h expected 10c", bus_b.signature);
        end
      end
    end
    checks++;
    if (edges != 8) begin errors++; $display("FAIL b_latency: done after edge %0d expected 8", edges); end
    checks++;
    if (bus_b.signature !== 9'h019 || bus_b.pass !== 1'b0) begin
      errors++; $display("FAIL b_signature: sig %h pass %b expected 019 0", bus_b.signature, bus_b.pass);
    end
    checks++;
    if (n_en != 4 || n_tm != 6 || bus_b.pattern_cnt !== 10'd4) begin
      errors++; $display("FAIL b_mode_cycles: en %0d test_mode %0d cnt %0d expected 4 6 4",
        n_en, n_tm, bus_b.pattern_cnt);
    end
  endtask

  task automatic test_abort();
    bus_c.cut_resp = 9'h000;
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus_c.lfsr_en !== 1'b1 || bus_c.busy !== 1'b1) begin
      errors++; $display("FAIL c_third_run: en %b busy %b expected 1 1", bus_c.lfsr_en, bus_c.busy);
    end
    bus_c.abort = 1'b1;
    tick();
    bus_c.abort = 1'b0;
    checks++;
    if ({bus_c.busy, bus_c.done, bus_c.lfsr_en, bus_c.test_mode, bus_c.lfsr_load, bus_c.pass} !== 6'b0) begin
      errors++; $display("FAIL c_abort: got %b expected 000000",
        {bus_c.busy, bus_c.done, bus_c.lfsr_en, bus_c.test_mode, bus_c.lfsr_load, bus_c.pass});
    end
    bus_c.start = 1'b1;
    bus_c.abort = 1'b1;
    tick();
    bus_c.start = 1'b0;
    bus_c.abort = 1'b0;
    checks++;
    if (bus_c.busy !== 1'b0 || bus_c.lfsr_load !== 1'b0) begin
      errors++; $display("FAIL c_abort_wins: busy %b load %b expected 0 0", bus_c.busy, bus_c.lfsr_load);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int edges = 0, n_load, n_en = 0;
    bus_c.cut_resp = 9'h000;
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    n_load = int'(bus_c.lfsr_load);
    while (bus_c.done !== 1'b1 && edges < 60) begin
      bus_c.start = (edges == 3 || edges == 9 || edges == 10);
      tick();
      edges++;
      n_load += int'(bus_c.lfsr_load);
      n_en   += int'(bus_c.lfsr_en);
    end
    bus_c.start = 1'b0;
    checks++;
    if (edges != 11) begin errors++; $display("FAIL c_busy_latency: done after edge %0d expected 11", edges); end
    checks++;
    if (n_load != 1 || n_en != 8) begin
      errors++; $display("FAIL c_busy_restart: load %0d en %0d expected 1 8", n_load, n_en);
    end
    checks++;
    if (bus_c.pattern_cnt !== 10'd8 || bus_c.signature !== 9'h000 || bus_c.pass !== 1'b1) begin
      errors++; $display("FAIL c_busy_result: cnt %0d sig %h pass %b expected 8 000 1",
        bus_c.pattern_cnt, bus_c.signature, bus_c.pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges = 0, n_en = 0;
    bus_c.cut_resp = 9'h0AB;
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus_c.signature !== 9'h0AB) begin
      errors++; $display("FAIL c_pre_reset_sig: sig %h expected 0ab", bus_c.signature);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_c.busy, bus_c.done, bus_c.pass, bus_c.lfsr_en, bus_c.test_mode, bus_c.lfsr_load} !== 6'b0 ||
        bus_c.signature !== 9'h000 || bus_c.pattern_cnt !== 10'd0) begin
      errors++; $display("FAIL c_async_reset: ctrl %b sig %h cnt %0d expected 000000 000 0",
        {bus_c.busy, bus_c.done, bus_c.pass, bus_c.lfsr_en, bus_c.test_mode, bus_c.lfsr_load},
        bus_c.signature, bus_c.pattern_cnt);
    end
    reset = 1'b0;
    bus_c.cut_resp = 9'h000;
    tick();
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    while (bus_c.done !== 1'b1 && edges < 60) begin
      tick();
      edges++;
      n_en += int'(bus_c.lfsr_en);
    end
    checks++;
    if (edges != 11 || n_en != 8 || bus_c.pass !== 1'b1 || bus_c.pattern_cnt !== 10'd8) begin
      errors++; $display("FAIL c_after_reset: edges %0d en %0d pass %b cnt %0d expected 11 8 1 8",
        edges, n_en, bus_c.pass, bus_c.pattern_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_session_a();
    test_back_to_back();
    test_resp_latency();
    test_abort();
    test_start_while_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
